dm_responder: RTL
=================

Name: dm_responder

Overview:
- Data-memory bus responder on the CPU load/store path.
- Accepts one request at a time from the CPU-side memory initiator: address, size, sign-extend select, write enable, write data.
- Services the request against an internal word array with a programmable number of wait states.
- Returns read data, or a write acknowledge, through a valid/ready response handshake.

Parameters:
- ADDR_W, 8, byte-address width; array depth is 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and access (0..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_siz  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_se  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator consumes response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal-size request.

Behaviour:
- Reset (async, rst_=1): state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not reset and are preserved across reset.
  - An in-flight request is discarded; a pending store never commits.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, latch we/addr/siz/se/wdata.
  - Go to WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - req_ready=0; counter counts up from 0.
  - Go to ACCESS on the edge where counter==WAIT_CYCLES-1.
- ACCESS (one cycle), resolved at the edge leaving ACCESS:
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; siz=3 always errors.
  - Error: rsp_err=1, rsp_rdata=0, no array write.
  - Store: byte-lane write at word index addr[ADDR_W-1:2].
    - Byte: lane addr[1:0] gets wdata[7:0].
    - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], little-endian.
    - Word: all four lanes.
    - Other lanes unchanged; rsp_rdata=0.
  - Load: select byte/half from the word by addr[1:0], then extend per req_se into rsp_rdata.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until consumed.
  - On rsp_ready=1 at an edge: rsp_valid=0, rsp_err=0, return to IDLE. req_ready rises the same edge.
  - A new request can be accepted no earlier than the edge after the return to IDLE.
- Latency: request accepted at edge E0 -> rsp_valid high after edge E0+WAIT_CYCLES+1. Throughput one request per WAIT_CYCLES+3 cycles with rsp_ready held high.
- req_valid outside IDLE is ignored. The initiator must hold the request until req_ready, which is naturally satisfied in IDLE.
- Store-then-load of the same address: the load observes the committed store data.
- Reset asserted in any state returns to IDLE immediately (async); rsp_valid drops without an edge.

Optional Feature:
- Macro: DM_RESPONDER_MMIO_LED_EN.
- Defined:
  - Adds output port led, width 16, reset 0.
  - Word address with all index bits set (top word, 0xFC at ADDR_W=8) is a memory-mapped LED register, not array storage.
  - Word store writes led=wdata[15:0]. Byte and half stores update only the addressed lanes that fall within [15:0]; lanes 2-3 are ignored.
  - Loads return {16'b0, led}, then apply the normal lane select and extend.
- Undefined: no led port; the top word is ordinary array storage.

Test Plan:
- Reset then idle: rst_=1 pulse -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Word store/load, WAIT_CYCLES=2, rsp_ready=1:
  - Store 0x8765_4321 to 0x10 -> rsp_valid 3 edges after acceptance, rsp_err=0.
  - Load word 0x10 -> rsp_rdata=0x8765_4321.
- Byte/half extension, after the store above:
  - Byte 0x13, se=1 -> 0xFFFF_FF87.
  - Byte 0x13, se=0 -> 0x0000_0087.
  - Half 0x12, se=1 -> 0xFFFF_8765.
  - Half 0x10, se=0 -> 0x0000_4321.
- Partial store: byte store 0xAA to 0x11 -> word load 0x10 = 0x8765_AA21.
- Misalignment and illegal size:
  - Half load at 0x11 -> rsp_err=1, rsp_rdata=0.
  - Word store at 0x12 -> rsp_err=1; word 0x10 unchanged.
  - siz=3 -> rsp_err=1.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout.
  - Store to 0x20 with rst_ pulsed during WAIT -> outputs at reset values; word 0x20 retains its prior value.

Source files
------------

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory bus responder with wait states and sized, sign/zero-extended loads
// Optional build macro DM_RESPONDER_MMIO_LED_EN maps the top word onto a 16-bit led register.
module dm_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_siz,
    input  logic              req_se,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
`ifdef DM_RESPONDER_MMIO_LED_EN
    ,output logic [15:0]      led
`endif
);

    localparam int         DEPTH     = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          siz_q, siz_d;
    logic                se_q, se_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         mem_q [DEPTH];

    logic [ADDR_W-3:0]   idx;
    logic [1:0]          lane;
    logic                acc_err;
    logic                do_write;
    logic                mem_wr;
    logic [31:0]         cur_word;
    logic [31:0]         wlane;
    logic [3:0]          be;
    logic [31:0]         merged;
    logic [31:0]         shifted;
    logic [31:0]         load_val;

`ifdef DM_RESPONDER_MMIO_LED_EN
    logic [15:0]         led_q, led_d;
    logic                mmio_hit;
    assign led = led_q;
`endif

    // State register; reset abandons any in-flight request
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: accept in IDLE, count wait states, one access cycle, hold response until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (cnt_q == WAIT_LAST) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Access decode: alignment, lane enables, store merge and load extraction
    always_comb begin
        idx      = addr_q[ADDR_W-1:2];
        lane     = addr_q[1:0];
        acc_err  = (siz_q == 2'd3) ||
                   ((siz_q == 2'd1) && addr_q[0]) ||
                   ((siz_q == 2'd2) && (addr_q[1:0] != 2'b00));
`ifdef DM_RESPONDER_MMIO_LED_EN
        mmio_hit = &idx;
        cur_word = mmio_hit ? {16'h0000, led_q} : mem_q[idx];
`else
        cur_word = mem_q[idx];
`endif
        case (siz_q)
            2'd0:    begin be = 4'b0001 << lane;                     wlane = {4{wdata_q[7:0]}};  end
            2'd1:    begin be = addr_q[1] ? 4'b1100 : 4'b0011;       wlane = {2{wdata_q[15:0]}}; end
            2'd2:    begin be = 4'b1111;                             wlane = wdata_q;            end
            default: begin be = 4'b0000;                             wlane = wdata_q;            end
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = be[b] ? wlane[b*8 +: 8] : cur_word[b*8 +: 8];
        end
        shifted = cur_word >> {lane, 3'b000};
        case (siz_q)
            2'd0:    load_val = {{24{se_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{se_q & shifted[15]}}, shifted[15:0]};
            default: load_val = cur_word;
        endcase
        do_write = (state_q == S_ACCESS) && we_q && !acc_err;
`ifdef DM_RESPONDER_MMIO_LED_EN
        mem_wr   = do_write && !mmio_hit;
`else
        mem_wr   = do_write;
`endif
    end

    // Datapath next values: latch request, count waits, capture result, clear on consume
    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        siz_d   = siz_q;
        se_d    = se_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DM_RESPONDER_MMIO_LED_EN
        led_d   = (do_write && mmio_hit) ? merged[15:0] : led_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    siz_d   = req_siz;
                    se_d    = req_se;
                    wdata_d = req_wdata;
                end
            end
            S_WAIT:   cnt_d = cnt_q + 4'd1;
            S_ACCESS: begin
                err_d   = acc_err;
                rdata_d = (acc_err || we_q) ? 32'h0 : load_val;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            siz_q   <= 2'd0;
            se_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef DM_RESPONDER_MMIO_LED_EN
            led_q   <= 16'h0000;
`endif
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            siz_q   <= siz_d;
            se_q    <= se_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DM_RESPONDER_MMIO_LED_EN
            led_q   <= led_d;
`endif
        end
    end

    // Word array; contents survive reset, commits only on the edge leaving ACCESS
    always_ff @(posedge clk) begin
        if (mem_wr) mem_q[idx] <= merged;
    end

endmodule
